// File: rtl/uart_pkg.sv
// Shared UART definitions: frame FSM states, default bit timing, data width and parity helper.
// The PARITY state exists only when UART_TX_PARITY_EN is defined.
package uart_pkg;

    localparam int CLKS_PER_BIT_DEFAULT = 5208;
    localparam int UART_DATA_BITS       = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } uart_state_t;

    function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Single-clock transmit FIFO with occupancy count; pushes while full and pops while empty
// are ignored. Read data is the current head entry (show-ahead).
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             push,
    input  logic                             pop,
    input  logic [UART_DATA_BITS-1:0]        wdata,
    output logic [UART_DATA_BITS-1:0]        rdata,
    output logic                             full,
    output logic                             empty,
    output logic [$clog2(DEPTH+1)-1:0]       count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [UART_DATA_BITS-1:0] mem_r [DEPTH];
    logic [AW-1:0]             wr_ptr_r;
    logic [AW-1:0]             rd_ptr_r;
    logic [CW-1:0]             count_r;
    logic                      push_s;
    logic                      pop_s;

    assign full   = (count_r == CW'(DEPTH));
    assign empty  = (count_r == CW'(0));
    assign count  = count_r;
    assign rdata  = mem_r[rd_ptr_r];
    assign push_s = push && !full;
    assign pop_s  = pop && !empty;

    // Storage array; contents are don't-care until written, so it carries no reset
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_r <= AW'(0);
            rd_ptr_r <= AW'(0);
            count_r  <= CW'(0);
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: FIFO-buffered, LSB-first 8N1 frames; optional even parity bit
// when UART_TX_PARITY_EN is defined (frames become 8E1).
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic [7:0]                        tx_data,
    input  logic                              tx_valid,
    output logic                              tx_ready,
    output logic                              tx,
    output logic                              busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count
);

    localparam int             BW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0]  BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]     BIT_LAST  = 3'(UART_DATA_BITS - 1);

    uart_state_t               state_r, state_next_s;
    logic [BW-1:0]             baud_r, baud_next_s;
    logic [2:0]                bit_idx_r, bit_idx_next_s;
    logic [UART_DATA_BITS-1:0] shift_r, shift_next_s;
    logic                      tx_r, tx_s;
    logic                      bit_end_s;
    logic                      push_s, pop_s;
    logic                      fifo_full_s, fifo_empty_s;
    logic [UART_DATA_BITS-1:0] fifo_rdata_s;
`ifdef UART_TX_PARITY_EN
    logic                      parity_r, parity_next_s;
`endif

    assign tx_ready  = !fifo_full_s;
    assign push_s    = tx_valid && !fifo_full_s;
    assign bit_end_s = (baud_r == BAUD_LAST);
    assign tx        = tx_r;
    assign busy      = (state_r != IDLE) || (fifo_count != '0);

    uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push_s),
        .pop     (pop_s),
        .wdata   (tx_data),
        .rdata   (fifo_rdata_s),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s),
        .count   (fifo_count)
    );

    // Next-state and line-level decode; tx_s reflects the current state and is
    // registered below, so the line trails the state by exactly one cycle
    always_comb begin
        state_next_s   = state_r;
        baud_next_s    = baud_r + BW'(1);
        bit_idx_next_s = bit_idx_r;
        shift_next_s   = shift_r;
        pop_s          = 1'b0;
        tx_s           = 1'b1;
`ifdef UART_TX_PARITY_EN
        parity_next_s  = parity_r;
`endif
        case (state_r)
            IDLE: begin
                baud_next_s = BW'(0);
                if (!fifo_empty_s) begin
                    pop_s        = 1'b1;
                    shift_next_s = fifo_rdata_s;
`ifdef UART_TX_PARITY_EN
                    parity_next_s = even_parity(fifo_rdata_s);
`endif
                    state_next_s = START;
                end else begin
                    state_next_s = IDLE;
                end
            end
            START: begin
                tx_s = 1'b0;
                if (bit_end_s) begin
                    baud_next_s    = BW'(0);
                    bit_idx_next_s = 3'd0;
                    state_next_s   = DATA;
                end else begin
                    state_next_s = START;
                end
            end
            DATA: begin
                tx_s = shift_r[0];
                if (bit_end_s) begin
                    baud_next_s  = BW'(0);
                    shift_next_s = {1'b0, shift_r[UART_DATA_BITS-1:1]};
                    if (bit_idx_r == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                        state_next_s = PARITY;
`else
                        state_next_s = STOP;
`endif
                    end else begin
                        bit_idx_next_s = bit_idx_r + 3'd1;
                    end
                end else begin
                    state_next_s = DATA;
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                tx_s = parity_r;
                if (bit_end_s) begin
                    baud_next_s  = BW'(0);
                    state_next_s = STOP;
                end else begin
                    state_next_s = PARITY;
                end
            end
`endif
            STOP: begin
                tx_s = 1'b1;
                if (bit_end_s) begin
                    baud_next_s = BW'(0);
                    if (!fifo_empty_s) begin
                        pop_s        = 1'b1;
                        shift_next_s = fifo_rdata_s;
`ifdef UART_TX_PARITY_EN
                        parity_next_s = even_parity(fifo_rdata_s);
`endif
                        state_next_s = START;
                    end else begin
                        state_next_s = IDLE;
                    end
                end else begin
                    state_next_s = STOP;
                end
            end
            default: begin
                baud_next_s  = BW'(0);
                state_next_s = IDLE;
            end
        endcase
    end

    // Frame state, counters, shifter and the registered serial line
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r   <= IDLE;
            baud_r    <= BW'(0);
            bit_idx_r <= 3'd0;
            shift_r   <= {UART_DATA_BITS{1'b0}};
            tx_r      <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_r  <= 1'b0;
`endif
        end else begin
            state_r   <= state_next_s;
            baud_r    <= baud_next_s;
            bit_idx_r <= bit_idx_next_s;
            shift_r   <= shift_next_s;
            tx_r      <= tx_s;
`ifdef UART_TX_PARITY_EN
            parity_r  <= parity_next_s;
`endif
        end
    end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 5208, meaning clk cycles per UART bit (50 MHz / 9600 baud).
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, meaning transmit FIFO entries; power of two, minimum 2.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port tx_data, input, 8 bits: byte to send.
REQ-006 SHALL have port tx_valid, input, 1 bit: tx_data is valid.
REQ-007 SHALL have port tx_ready, output, 1 bit: the FIFO can accept a byte.
REQ-008 SHALL have port tx, output, 1 bit: serial line, idle high.
REQ-009 SHALL have port busy, output, 1 bit: a frame is in progress or the FIFO is non-empty.
REQ-010 SHALL have port fifo_count, output, $clog2(FIFO_DEPTH+1) bits: current FIFO occupancy.

Function
REQ-011 SHALL accept a byte on a rising edge where tx_valid and tx_ready are both high; no other edge pushes.
REQ-012 SHALL drive tx_ready = !full, derived from registered state only; it has no combinational path from tx_valid.
REQ-013 SHALL ignore tx_valid while full; the byte is not accepted and tx_data is not sampled.
REQ-014 SHALL use a frame FSM with states IDLE, START, DATA, PARITY (macro only), STOP.
REQ-015 IDLE: tx=1; if FIFO non-empty, pop the head byte into a shift register and go to START on the same edge.
REQ-016 START: tx=0 for CLKS_PER_BIT cycles, then go to DATA.
REQ-017 DATA: send 8 bits LSB first, each for CLKS_PER_BIT cycles; a 3-bit index counts 0..7; after bit 7, go to PARITY (macro defined) or STOP.
REQ-018 STOP: tx=1 for CLKS_PER_BIT cycles; then pop the next byte and go directly to START if the FIFO is non-empty, else go to IDLE.
REQ-019 Back-to-back frames SHALL have zero idle cycles between the stop bit and the next start bit.
REQ-020 Latency: with the FIFO empty and the FSM in IDLE, tx SHALL fall on the 2nd rising edge after the accepting edge.
REQ-021 Frame length SHALL be exactly 10*CLKS_PER_BIT cycles, or 11*CLKS_PER_BIT with parity.
REQ-022 The baud counter SHALL count 0..CLKS_PER_BIT-1 and reset to 0 on every state or bit change.
REQ-023 On a simultaneous push and pop, fifo_count SHALL be unchanged and both operations SHALL take effect.
REQ-024 FIFO pointers SHALL wrap modulo FIFO_DEPTH; fifo_count SHALL saturate at neither end: no push when full, no pop when empty.
REQ-025 The tx output SHALL be registered (glitch-free).
REQ-026 busy SHALL equal (state != IDLE) || (fifo_count != 0).

Reset
REQ-027 On a rising edge with reset_n=0: state=IDLE, tx=1, FIFO emptied (fifo_count=0, pointers=0), tx_ready=1, busy=0, counters=0.
REQ-028 Reset asserted mid-frame SHALL abandon the frame; tx SHALL be high from the next edge, with no partial stop bit required.
REQ-029 A tx_valid presented during reset SHALL NOT be accepted.

Configuration
REQ-030 Macro UART_TX_PARITY_EN: when defined, insert an even-parity bit (XOR of the 8 data bits) after bit 7, lasting CLKS_PER_BIT cycles.
REQ-031 When UART_TX_PARITY_EN is undefined, the PARITY state and its logic SHALL be absent and frames SHALL be 8N1.

Structure
REQ-032 A shared package uart_pkg SHALL hold the FSM state typedef, the default CLKS_PER_BIT, and UART_DATA_BITS=8.
REQ-033 The FIFO SHALL be one sub-module, uart_tx_fifo (synchronous, single clock, same reset); the FSM and shifter SHALL stay in uart_tx.

Verification
REQ-034 CLKS_PER_BIT=4, push 0x55 -> tx low 4 cycles, then 1,0,1,0,1,0,1,0 each 4 cycles, then high 4 cycles; busy deasserts after the stop bit.
REQ-035 UART_TX_PARITY_EN defined, push 0x07 -> parity bit=1; push 0x03 -> parity bit=0; frame is 44 cycles at CLKS_PER_BIT=4.
REQ-036 Hold tx_valid with the FSM busy -> tx_ready falls after 8 accepts (fifo_count=8) and the 9th byte is held until a pop; all 9 bytes are sent in order.
REQ-037 Push 0xA0, 0x5A consecutively -> the second start bit immediately follows the first stop bit, with no gap cycles.
REQ-038 Assert reset_n=0 for 1 cycle mid DATA bit 3 -> tx=1 next edge, fifo_count=0, no further frame.
REQ-039 Loop tx into the existing UART receiver (same CLKS_PER_BIT), push 90 then 180 -> receiver reports data_ready with 90, then 180.
